cart_mapper: RTL and testbench

Bank-switched expansion-port cartridge, the device on the far side of the memory-map decoder. It consumes the decoder's ROML/ROMH/IO1/IO2 selects and drives _GAME/_EXROM back into the decoder. It fetches ROM bytes from an external image memory over a request/acknowledge handshake and drives them onto the CPU data bus. It also exposes a bank/mode register file at $DE00/$DE01.

---
 rtl/cart_mapper.sv | 198 +++++++++++++++++++
 tb/tb_cart_mapper.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_mapper.sv
// rtl/cart_mapper.sv - bank-switched expansion-port cartridge; optional freeze logic under CART_FREEZE_EN
module cart_mapper #(
    parameter int         BANK_BITS  = 6,
    parameter logic [1:0] RESET_MODE = 2'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cyc_start,
    input  logic                    cyc_end,
    input  logic [15:0]             A,
    input  logic                    R__W,
    input  logic                    ROML,
    input  logic                    ROMH,
    input  logic                    IO1,
    input  logic                    IO2,
    input  logic [7:0]              d_in,
    output logic [7:0]              d_out,
    output logic                    d_oe,
    output logic                    _GAME,
    output logic                    _EXROM,
    output logic                    rom_req,
    output logic [BANK_BITS+13:0]   rom_addr,
    input  logic                    rom_ack,
    input  logic [7:0]              rom_data,
    input  logic                    freeze_btn,
    output logic                    _NMI
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;
    localparam logic [1:0] S_ABORT = 2'd3;

    logic [BANK_BITS-1:0]  bank;
    logic [1:0]            mode;
    logic                  dis;
    logic [1:0]            state;

    logic                  reg_wr;
    logic                  bank_wr;
    logic                  mode_wr;
    logic                  frozen;
    logic                  freeze_hit;
    logic                  eff_dis;
    logic [1:0]            eff_mode;
    logic [BANK_BITS-1:0]  eff_bank;
    logic                  rd_en;
    logic                  rom_sel;
    logic [6:0]            bank7;
    logic [7:0]            reg_rd;
    logic [BANK_BITS+13:0] next_addr;
    logic                  unused_inputs;

    assign reg_wr  = cyc_end && IO1 && !R__W;
    assign bank_wr = reg_wr && !A[0];
    assign mode_wr = reg_wr && A[0];

    // Inputs only some configurations consume are collected here.
    assign unused_inputs = ^{A, d_in, freeze_btn};

`ifdef CART_FREEZE_EN
    localparam logic [1:0] F_IDLE   = 2'd0;
    localparam logic [1:0] F_ARMED  = 2'd1;
    localparam logic [1:0] F_FROZEN = 2'd2;

    logic [1:0] fstate;
    logic       btn_q;

    assign frozen     = (fstate == F_FROZEN);
    // The NMI vector fetch itself is the first access served from the frozen map.
    assign freeze_hit = (fstate == F_ARMED) && (state == S_IDLE) && cyc_start &&
                        R__W && ROMH && (A == 16'hFFFA);
    assign _NMI       = (fstate != F_ARMED);

    // Freeze sequencing: button edge arms, NMI vector fetch freezes, $DE00 write releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            fstate <= F_IDLE;
            btn_q  <= 1'b0;
        end else begin
            btn_q <= freeze_btn;
            case (fstate)
                F_IDLE:   if (freeze_btn && !btn_q) fstate <= F_ARMED;
                F_ARMED:  if (freeze_hit) fstate <= F_FROZEN;
                F_FROZEN: if (bank_wr) fstate <= F_IDLE;
                default:  fstate <= F_IDLE;
            endcase
        end
    end
`else
    assign frozen     = 1'b0;
    assign freeze_hit = 1'b0;
    assign _NMI       = 1'b1;
`endif

    assign eff_dis  = dis && !frozen;
    assign eff_mode = frozen ? 2'd2 : mode;
    assign eff_bank = (frozen || freeze_hit) ? '0 : bank;
    assign rd_en    = cyc_start && R__W && (state == S_IDLE) && (!eff_dis || freeze_hit);
    assign rom_sel  = ROML || ROMH || IO2;
    assign bank7    = 7'(bank);
    assign reg_rd   = A[0] ? {6'b0, mode} : {dis, bank7};

    // Image address for the selected window; IO2 aliases the top page of ROML.
    always_comb begin
        next_addr = {eff_bank, 1'b0, A[12:0]};
        if (ROML)
            next_addr = {eff_bank, 1'b0, A[12:0]};
        else if (ROMH)
            next_addr = {eff_bank, 1'b1, A[12:0]};
        else if (IO2)
            next_addr = {eff_bank, 1'b0, 5'h1F, A[7:0]};
    end

    // Bank/mode register file; dis is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank <= '0;
            mode <= RESET_MODE;
            dis  <= 1'b0;
        end else begin
            if (bank_wr) begin
                bank <= d_in[BANK_BITS-1:0];
                dis  <= dis | d_in[7];
            end
            if (mode_wr)
                mode <= d_in[1:0];
        end
    end

    // Registered config lines, one clk behind the mode/dis/freeze state.
    always_ff @(posedge clk) begin
        if (rst) begin
            _EXROM <= RESET_MODE[1];
            _GAME  <= ~(RESET_MODE[0] ^ RESET_MODE[1]);
        end else if (eff_dis) begin
            _EXROM <= 1'b1;
            _GAME  <= 1'b1;
        end else begin
            _EXROM <= eff_mode[1];
            _GAME  <= ~(eff_mode[0] ^ eff_mode[1]);
        end
    end

    // Read engine: register reads drive immediately, ROM reads go through the image handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rom_req  <= 1'b0;
            rom_addr <= '0;
            d_out    <= 8'h00;
            d_oe     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rd_en && IO1) begin
                        d_out <= reg_rd;
                        d_oe  <= 1'b1;
                        state <= S_DRIVE;
                    end else if (rd_en && rom_sel) begin
                        rom_addr <= next_addr;
                        rom_req  <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (rom_ack) begin
                        rom_req <= 1'b0;
                        if (cyc_end) begin
                            // Data arrived as the bus cycle closed: nothing left to drive.
                            state <= S_IDLE;
                        end else begin
                            d_out <= rom_data;
                            d_oe  <= 1'b1;
                            state <= S_DRIVE;
                        end
                    end else if (cyc_end) begin
                        state <= S_ABORT;
                    end
                end
                S_DRIVE: begin
                    if (cyc_end) begin
                        d_oe  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    // Late acknowledge: hold the request until the image memory answers, then drop it.
                    if (rom_ack) begin
                        rom_req <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_mapper.sv
// tb/tb_cart_mapper.sv - randomized self-checking bench for cart_mapper against a behavioural model
module tb_cart_mapper;

    localparam int BB = 6;

    logic          clk = 1'b0;
    logic          rst, cyc_start, cyc_end, R__W, ROML, ROMH, IO1, IO2, rom_ack, freeze_btn;
    logic [15:0]   A;
    logic [7:0]    d_in, rom_data, d_out;
    logic          d_oe, _GAME, _EXROM, rom_req, _NMI;
    logic [BB+13:0] rom_addr;

    int checks   = 0;
    int failures = 0;

    int m_bank = 0;
    int m_mode = 0;
    int m_dis  = 0;
    int m_frozen = 0;

    cart_mapper #(.BANK_BITS(BB), .RESET_MODE(2'd0)) dut (
        .clk(clk), .rst(rst), .cyc_start(cyc_start), .cyc_end(cyc_end), .A(A), .R__W(R__W),
        .ROML(ROML), .ROMH(ROMH), .IO1(IO1), .IO2(IO2), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
        ._GAME(_GAME), ._EXROM(_EXROM), .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
        .rom_data(rom_data), .freeze_btn(freeze_btn), ._NMI(_NMI)
    );

    always #5 clk = ~clk;

    // Byte offset into the image: 16 KB per bank, ROMH is the upper 8 KB, IO2 is the last ROML page.
    function automatic int exp_addr(input int bank, input int sel, input int a);
        if (sel == 0) return bank * 16384 + (a % 8192);
        if (sel == 1) return bank * 16384 + 8192 + (a % 8192);
        return bank * 16384 + 31 * 256 + (a % 256);
    endfunction

    // {_EXROM, _GAME} for a given mode and disable flag.
    function automatic logic [1:0] exp_lines(input int mode, input int dis);
        if (dis != 0) return 2'b11;
        case (mode)
            0: return 2'b01;
            1: return 2'b00;
            2: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        cyc_start = 0; cyc_end = 0; ROML = 0; ROMH = 0; IO1 = 0; IO2 = 0;
        R__W = 1; rom_ack = 0;
    endtask

    task automatic set_sel(input int sel);
        ROML = (sel == 0); ROMH = (sel == 1); IO2 = (sel == 2);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        A = addr; R__W = 0; IO1 = 1; d_in = data;
        cyc_start = 1; tick; cyc_start = 0;
        tick;
        cyc_end = 1; tick; cyc_end = 0;
        bus_idle;
        if (addr[0] == 1'b0) begin
            m_bank = data % 64;
            if (data[7]) m_dis = 1;
            m_frozen = 0;
        end else begin
            m_mode = data % 4;
        end
    endtask

    task automatic check_lines(input string name);
        logic [1:0] exp;
        exp = m_frozen ? 2'b10 : exp_lines(m_mode, m_dis);
        checks++;
        if ({_EXROM, _GAME} !== exp) begin
            failures++;
            $display("FAIL %s lines got=%b exp=%b", name, {_EXROM, _GAME}, exp);
        end
    endtask

    task automatic rom_read(input int sel, input logic [15:0] addr, input logic [7:0] data,
                            input int delay, input int ebank, input string name);
        logic [19:0] exp;
        exp = 20'(exp_addr(ebank, sel, addr));
        A = addr; R__W = 1; set_sel(sel);
        cyc_start = 1; tick; cyc_start = 0;
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== exp) begin
            failures++;
            $display("FAIL %s req/addr got=%b/%h exp=1/%h", name, rom_req, rom_addr, exp);
        end
        for (int i = 0; i < delay; i++) tick;
        checks++;
        if (d_oe !== 1'b0) begin
            failures++;
            $display("FAIL %s early d_oe got=%b exp=0", name, d_oe);
        end
        rom_data = data; rom_ack = 1; tick; rom_ack = 0;
        checks++;
        if (d_oe !== 1'b1 || d_out !== data || rom_req !== 1'b0) begin
            failures++;
            $display("FAIL %s drive got oe=%b d=%h req=%b exp oe=1 d=%h req=0", name, d_oe, d_out, rom_req, data);
        end
        tick;
        checks++;
        if (d_oe !== 1'b1) begin
            failures++;
            $display("FAIL %s hold d_oe got=%b exp=1", name, d_oe);
        end
        cyc_end = 1; tick; cyc_end = 0;
        checks++;
        if (d_oe !== 1'b0) begin
            failures++;
            $display("FAIL %s release d_oe got=%b exp=0", name, d_oe);
        end
        bus_idle;
    endtask

    task automatic reg_read(input logic [15:0] addr, input string name);
        logic [7:0] exp;
        exp = addr[0] ? 8'(m_mode) : 8'(m_dis * 128 + m_bank);
        A = addr; R__W = 1; IO1 = 1;
        cyc_start = 1; tick; cyc_start = 0;
        checks++;
        if (d_oe !== 1'b1 || d_out !== exp) begin
            failures++;
            $display("FAIL %s got oe=%b d=%h exp oe=1 d=%h", name, d_oe, d_out, exp);
        end
        cyc_end = 1; tick; cyc_end = 0;
        checks++;
        if (d_oe !== 1'b0) begin
            failures++;
            $display("FAIL %s release d_oe got=%b exp=0", name, d_oe);
        end
        bus_idle;
    endtask

    task automatic apply_reset;
        rst = 1; tick; tick; rst = 0;
        m_bank = 0; m_mode = 0; m_dis = 0; m_frozen = 0;
    endtask

    task automatic test_reset;
        bus_idle; A = 16'h0000; d_in = 8'h00; rom_data = 8'h00; freeze_btn = 0;
        apply_reset;
        checks++;
        if (d_out !== 8'h00 || d_oe !== 1'b0 || rom_req !== 1'b0 || rom_addr !== 20'h0 || _NMI !== 1'b1) begin
            failures++;
            $display("FAIL reset outputs got d=%h oe=%b req=%b addr=%h nmi=%b exp 00/0/0/00000/1",
                     d_out, d_oe, rom_req, rom_addr, _NMI);
        end
        check_lines("reset");
    endtask

    task automatic test_basic;
        rom_read(0, 16'h8123, 8'hA5, 2, m_bank, "roml_8123");
        do_write(16'hDE00, 8'h05);
        rom_read(1, 16'hA010, 8'h3C, 1, m_bank, "romh_a010");
        reg_read(16'hDE00, "rd_de00");
        do_write(16'hDE01, 8'h03);
        tick;
        check_lines("mode3");
        reg_read(16'hDE01, "rd_de01");
        do_write(16'hDE80, 8'h02);
        rom_read(2, 16'hDF42, 8'h77, 0, m_bank, "io2_df42");
        do_write(16'hDEFF, 8'h00);
        tick;
        check_lines("mode0_mirror");
    endtask

    task automatic test_late_ack;
        logic [19:0] exp;
        exp = 20'(exp_addr(m_bank, 0, 16'h8456));
        A = 16'h8456; R__W = 1; ROML = 1;
        cyc_start = 1; tick; cyc_start = 0;
        tick;
        cyc_end = 1; tick; cyc_end = 0;
        tick;
        checks++;
        if (rom_req !== 1'b1 || d_oe !== 1'b0) begin
            failures++;
            $display("FAIL late_hold got req=%b oe=%b exp req=1 oe=0", rom_req, d_oe);
        end
        A = 16'h8999;
        cyc_start = 1; tick; cyc_start = 0;
        checks++;
        if (rom_addr !== exp || rom_req !== 1'b1) begin
            failures++;
            $display("FAIL late_ignore_start got addr=%h req=%b exp addr=%h req=1", rom_addr, rom_req, exp);
        end
        rom_data = 8'hEE; rom_ack = 1; tick; rom_ack = 0;
        checks++;
        if (rom_req !== 1'b0 || d_oe !== 1'b0) begin
            failures++;
            $display("FAIL late_ack got req=%b oe=%b exp req=0 oe=0", rom_req, d_oe);
        end
        tick;
        checks++;
        if (d_oe !== 1'b0) begin
            failures++;
            $display("FAIL late_discard d_oe got=%b exp=0", d_oe);
        end
        bus_idle;
        rom_read(0, 16'h8777, 8'h5A, 1, m_bank, "after_late");
    endtask

    task automatic test_random;
        int op, sel, delay;
        logic [15:0] addr;
        logic [7:0] data;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 5);
            data = 8'($urandom_range(0, 255));
            if (op == 0) begin
                do_write(16'hDE00 | 16'($urandom_range(0, 127) * 2), data & 8'h7F);
                tick;
                check_lines("rand_bank_wr");
            end else if (op == 1) begin
                do_write(16'hDE01 | 16'($urandom_range(0, 127) * 2), data);
                tick;
                check_lines("rand_mode_wr");
            end else if (op == 5) begin
                reg_read(16'hDE00 | 16'($urandom_range(0, 255)), "rand_reg_rd");
            end else begin
                sel = $urandom_range(0, 2);
                if (sel == 0) addr = 16'h8000 | 16'($urandom_range(0, 8191));
                else if (sel == 1) addr = 16'hA000 | 16'($urandom_range(0, 8191));
                else addr = 16'hDF00 | 16'($urandom_range(0, 255));
                delay = $urandom_range(0, 3);
                rom_read(sel, addr, data, delay, m_bank, "rand_rom");
            end
        end
    endtask

    task automatic test_disable;
        do_write(16'hDE00, 8'h80);
        tick;
        check_lines("dis_set");
        do_write(16'hDE01, 8'h01);
        tick;
        check_lines("dis_mode1");
        A = 16'h8010; R__W = 1; ROML = 1;
        cyc_start = 1; tick; cyc_start = 0;
        tick;
        checks++;
        if (rom_req !== 1'b0 || d_oe !== 1'b0) begin
            failures++;
            $display("FAIL dis_roml got req=%b oe=%b exp 0/0", rom_req, d_oe);
        end
        cyc_end = 1; tick; bus_idle;
        A = 16'hDE00; IO1 = 1;
        cyc_start = 1; tick; cyc_start = 0;
        checks++;
        if (d_oe !== 1'b0) begin
            failures++;
            $display("FAIL dis_io1 d_oe got=%b exp=0", d_oe);
        end
        cyc_end = 1; tick; bus_idle;
        apply_reset;
        tick;
        check_lines("dis_cleared");
    endtask

    task automatic test_reset_midfetch;
        A = 16'h8100; R__W = 1; ROML = 1;
        cyc_start = 1; tick; cyc_start = 0;
        rst = 1; tick; rst = 0;
        checks++;
        if (rom_req !== 1'b0 || d_oe !== 1'b0) begin
            failures++;
            $display("FAIL rst_req got req=%b oe=%b exp 0/0", rom_req, d_oe);
        end
        bus_idle;
        A = 16'h8200; ROML = 1;
        cyc_start = 1; tick; cyc_start = 0;
        rom_data = 8'h11; rom_ack = 1; tick; rom_ack = 0;
        rst = 1; tick; rst = 0;
        checks++;
        if (d_oe !== 1'b0 || rom_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_drive got oe=%b req=%b exp 0/0", d_oe, rom_req);
        end
        bus_idle;
        m_bank = 0; m_mode = 0; m_dis = 0; m_frozen = 0;
        rom_read(1, 16'hB234, 8'h99, 1, m_bank, "after_rst");
    endtask

`ifdef CART_FREEZE_EN
    task automatic test_freeze;
        do_write(16'hDE00, 8'h05);
        do_write(16'hDE01, 8'h01);
        freeze_btn = 1; tick; tick;
        checks++;
        if (_NMI !== 1'b0) begin
            failures++;
            $display("FAIL frz_armed nmi got=%b exp=0", _NMI);
        end
        freeze_btn = 0;
        A = 16'hFFFA; R__W = 1; ROMH = 1;
        cyc_start = 1; tick; cyc_start = 0;
        checks++;
        if (_NMI !== 1'b1 || rom_addr !== 20'(exp_addr(0, 1, 16'hFFFA))) begin
            failures++;
            $display("FAIL frz_vector got nmi=%b addr=%h exp nmi=1 addr=%h", _NMI, rom_addr,
                     20'(exp_addr(0, 1, 16'hFFFA)));
        end
        m_frozen = 1;
        rom_data = 8'h43; rom_ack = 1; tick; rom_ack = 0;
        check_lines("frz_ultimax");
        cyc_end = 1; tick; bus_idle;
        do_write(16'hDE00, 8'h03);
        tick;
        check_lines("frz_release");
        reg_read(16'hDE00, "frz_bank3");
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_late_ack;
        test_random;
        test_disable;
        test_reset_midfetch;
`ifdef CART_FREEZE_EN
        test_freeze;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
